// File: rtl/dmem_unit.sv
// dmem_unit: word-organised 32-bit data memory for the core load/store port.
// Byte-addressed, byte-lane masked stores, registered loads with one-cycle
// latency, access checking, and a zero-fill sweep after every reset.
module dmem_unit #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_data_in,
  input  logic [3:0]  dm_wr_mask,
  input  logic        dm_wr_req,
  input  logic        dm_rd_req,
  output logic [31:0] dm_data_o,
  output logic        dm_rd_valid,
  output logic        dm_err,
  output logic        dm_busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_e;

  state_e state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic [31:0] mem_q [DEPTH];

  logic [31:0] data_q, data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        err_q, err_d;

  logic [AW-1:0] idx;
  logic          req;
  logic          misaligned;
  logic          out_of_range;
  logic          legal;
  logic          init_wr;
  logic          wr_en;

  // Address decode and legality of the current request.
  always_comb begin
    idx          = dm_addr[AW+1:2];
    req          = dm_wr_req | dm_rd_req;
    misaligned   = (dm_addr[1:0] != 2'b00);
    out_of_range = (dm_addr[31:AW+2] != '0);
    legal        = ~misaligned & ~out_of_range;
  end

  // State and sweep counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: the sweep walks every word once, then the unit stays idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs and next-cycle response; requests are only honoured when idle.
  always_comb begin
    dm_busy    = (state_q == ST_INIT);
    init_wr    = 1'b0;
    wr_en      = 1'b0;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    data_d     = data_q;
    unique case (state_q)
      ST_INIT: begin
        init_wr = ~rst;
      end
      ST_IDLE: begin
        if (req) begin
          err_d = ~legal;
          wr_en = dm_wr_req & legal & ~rst;
          if (dm_rd_req) begin
            rd_valid_d = 1'b1;
            // Array read sees pre-store contents, giving read-first on collision.
            data_d     = legal ? mem_q[idx] : '0;
          end
        end
      end
      default: begin
        dm_busy = 1'b1;
      end
    endcase
  end

  // Registered response; data is held when no read completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      data_q     <= data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // Storage array: zero-fill during the sweep, lane-masked stores when idle.
  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (dm_wr_mask[i]) begin
          mem_q[idx][8*i +: 8] <= dm_data_in[8*i +: 8];
        end
      end
    end
  end

  assign dm_data_o   = data_q;
  assign dm_rd_valid = rd_valid_q;
  assign dm_err      = err_q;

endmodule
